// File: rtl/spim_seq_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spim_seq_pkg;

  localparam int STATE_W         = 3;
  localparam int DEFAULT_TIMEOUT = 65535;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } seq_state_t;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spim_sequencer_if.sv
// Bus between the sequencer and the shared SPI master core.
interface spim_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int CS_W   = 1
) ();

  logic [DATA_W-1:0] m_data;
  logic [LEN_W-1:0]  m_len;
  logic [CS_W-1:0]   m_cs;
  logic              m_start;
  logic              m_idle;
  logic [DATA_W-1:0] m_miso;

  modport master (
    output m_data, m_len, m_cs, m_start,
    input  m_idle, m_miso
  );

  modport slave (
    input  m_data, m_len, m_cs, m_start,
    output m_idle, m_miso
  );

endinterface

// File: rtl/spim_sequencer_rr_arbiter.sv
// Round-robin winner selection with a registered priority pointer.
module rr_arbiter
  import spim_seq_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  input  logic [IDX_W-1:0] adv_idx,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  logic [IDX_W-1:0] ptr;

  // First requesting index at or above the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[IDX_W'(idx)]) begin
        any = 1'b1;
        win = IDX_W'(idx);
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (adv_idx == IDX_W'(N_REQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spim_sequencer.sv
// Shares one SPI master core between several requesters: arbitrate, load,
// start, wait for completion with timeout, and acknowledge the winner.
module spim_sequencer
  import spim_seq_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int DATA_W  = 16,
  parameter  int LEN_W   = 8,
  parameter  int CS_W    = 1,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDX_W   = idx_width(N_REQ)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  input  logic [N_REQ*CS_W-1:0]   req_cs,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        err,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  spim_sequencer_if.master        core
);

  localparam int CNT_W = 16;

  seq_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic             any;
  logic [IDX_W-1:0] win;
  logic             adv;
  logic             tmo;

  assign busy = (state != IDLE);
  assign adv  = (state == RESP);
  assign tmo  = (cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .req     (req),
    .adv     (adv),
    .adv_idx (grant),
    .any     (any),
    .win     (win)
  );

  // Sequencer FSM; ack/err are raised on entry to RESP so they are visible
  // in the RESP cycle itself, one cycle after the core reports idle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      grant        <= '0;
      cnt          <= '0;
      ack          <= '0;
      err          <= '0;
      rsp_data     <= '0;
      core.m_data  <= '0;
      core.m_len   <= '0;
      core.m_cs    <= '0;
      core.m_start <= 1'b0;
    end else begin
      core.m_start <= 1'b0;
      ack          <= '0;
      err          <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            grant       <= win;
            core.m_data <= req_data[int'(win)*DATA_W +: DATA_W];
            core.m_len  <= req_len[int'(win)*LEN_W +: LEN_W];
            core.m_cs   <= req_cs[int'(win)*CS_W +: CS_W];
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (core.m_idle) begin
            core.m_start <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tmo) begin
            ack        <= '0 | (N_REQ'(1) << grant);
            err        <= '0 | (N_REQ'(1) << grant);
            rsp_data   <= '0;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (!core.m_idle) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (core.m_idle) begin
            ack      <= '0 | (N_REQ'(1) << grant);
            rsp_data <= core.m_miso;
            state    <= RESP;
          end else if (tmo) begin
            ack      <= '0 | (N_REQ'(1) << grant);
            err      <= '0 | (N_REQ'(1) << grant);
            rsp_data <= '0;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spim_sequencer.sv
// Scoreboard bench for spim_sequencer with a loopback SPI core model.
module tb_spim_sequencer;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int CS_W   = 1;
  localparam int TMO    = 20;

  typedef struct {
    int               idx;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ*CS_W-1:0]   req_cs;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        err;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;

  spim_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CS_W(CS_W)) core_if ();

  spim_sequencer #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .CS_W    (CS_W),
    .TIMEOUT (TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .req_data (req_data),
    .req_len  (req_len),
    .req_cs   (req_cs),
    .ack      (ack),
    .err      (err),
    .rsp_data (rsp_data),
    .busy     (busy),
    .core     (core_if)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Core model: goes busy the cycle after m_start, stays busy core_lat+1
  // cycles (forever while core_hang), and loops the MOSI word back.
  logic              core_active;
  logic              core_hang = 1'b0;
  logic              ext_busy = 1'b0;
  int                core_lat = 3;
  int                core_cnt;
  logic [DATA_W-1:0] miso_q;

  assign core_if.m_idle = !core_active && !ext_busy;
  assign core_if.m_miso = miso_q;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      core_active <= 1'b0;
      core_cnt    <= 0;
      miso_q      <= '0;
    end else if (core_if.m_start) begin
      core_active <= 1'b1;
      core_cnt    <= core_lat;
      miso_q      <= core_if.m_data;
    end else if (core_active && !core_hang) begin
      if (core_cnt == 0) core_active <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end

  // Monitor: compare each ack against the scoreboard, police m_start.
  logic prev_start = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (ack != '0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack=%b err=%b, expected no ack", ack, err);
        end else begin
          exp_t e;
          logic [31:0] oh;
          e  = sb.pop_front();
          oh = 32'd1 << e.idx;
          chk("ack_grant", 32'(ack), oh);
          chk("err_flag", 32'(err), e.err ? oh : 32'd0);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end else if (err != '0) begin
        chk("err_without_ack", 32'(err), 32'd0);
      end
      if (core_if.m_start) begin
        chk("mstart_idle", 32'(core_if.m_idle), 32'd1);
        chk("mstart_width", 32'(prev_start), 32'd0);
      end
    end
    prev_start = core_if.m_start;
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    do begin tick(); n++; end while (!core_if.m_start && n < limit);
    if (!core_if.m_start) chk("wait_start_bound", 32'(n), 32'(limit + 1));
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin tick(); n++; end while (ack == '0 && n < limit);
    if (ack == '0) chk("wait_ack_bound", 32'(n), 32'(limit + 1));
  endtask

  task automatic push(input int idx, input logic [DATA_W-1:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  initial begin
    int n;
    int cnt_bad;
    sys_rst  = 1'b1;
    req      = '0;
    req_data = '0;
    req_len  = '0;
    req_cs   = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mstart", 32'(core_if.m_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp", 32'(rsp_data), 0);
    chk("rst_mdata", 32'(core_if.m_data), 0);
    chk("rst_mlen", 32'(core_if.m_len), 0);
    chk("rst_mcs", 32'(core_if.m_cs), 0);
    sys_rst = 1'b0;
    tick();

    // Contention: both held, grants alternate starting with requester 0
    req_data = {16'h2222, 16'h1111};
    req_len  = {8'd7, 8'd7};
    req_cs   = 2'b11;
    req      = 2'b11;
    push(0, 16'h1111, 0); push(1, 16'h2222, 0);
    push(0, 16'h1111, 0); push(1, 16'h2222, 0);
    for (int i = 0; i < 4; i++) wait_ack(60, n);
    req = '0;
    repeat (3) tick();

    // Single requester: minimum latency and descriptor latch
    req_data = {16'h0000, 16'haa55};
    req_len  = {8'd0, 8'd15};
    req_cs   = 2'b01;
    req      = 2'b01;
    push(0, 16'haa55, 0);
    tick();
    chk("single_busy", 32'(busy), 1);
    chk("single_mdata", 32'(core_if.m_data), 32'h aa55);
    chk("single_mlen", 32'(core_if.m_len), 15);
    chk("single_mcs", 32'(core_if.m_cs), 1);
    tick();
    chk("single_start_cycle2", 32'(core_if.m_start), 1);
    wait_ack(60, n);
    req = '0;
    repeat (5) tick();

    // Core busy at grant: LOAD holds until m_idle returns
    ext_busy = 1'b1;
    req_data = {16'h0000, 16'h1234};
    req      = 2'b01;
    push(0, 16'h1234, 0);
    cnt_bad = 0;
    repeat (11) begin
      tick();
      if (core_if.m_start || !busy) cnt_bad++;
    end
    chk("busy_core_no_start", 32'(cnt_bad), 0);
    ext_busy = 1'b0;
    tick();
    chk("busy_core_start", 32'(core_if.m_start), 1);
    tick();
    chk("busy_core_start_1cyc", 32'(core_if.m_start), 0);
    wait_ack(60, n);
    req = '0;
    repeat (3) tick();

    // Reset mid-transfer: pointer is at 1 here, so requester 1 wins first
    core_lat = 6;
    req_data = {16'h2222, 16'h1111};
    req      = 2'b11;
    tick();
    chk("pre_rst_grant1", 32'(core_if.m_data), 32'h2222);
    wait_start(10, n);
    tick();
    tick();
    chk("pre_rst_core_busy", 32'(core_if.m_idle), 0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    push(0, 16'h1111, 0);
    push(1, 16'h2222, 0);
    tick();
    chk("post_rst_grant0", 32'(core_if.m_data), 32'h1111);
    wait_ack(60, n);
    wait_ack(60, n);
    req = '0;
    core_lat = 3;
    repeat (3) tick();

    // Timeout: core never returns idle
    core_hang = 1'b1;
    req_data  = {16'h0000, 16'hbeef};
    req       = 2'b01;
    push(0, 16'h0000, 1);
    wait_start(10, n);
    chk("tmo_start_latency", 32'(n), 2);
    wait_ack(100, n);
    chk("tmo_latency", 32'(n), TMO + 1);
    req = '0;
    tick();
    req_data = {16'h4444, 16'h0000};
    req      = 2'b10;
    push(1, 16'h4444, 0);
    cnt_bad = 0;
    repeat (8) begin
      tick();
      if (core_if.m_start || !busy) cnt_bad++;
    end
    chk("tmo_load_stall", 32'(cnt_bad), 0);
    core_hang = 1'b0;
    wait_start(20, n);
    wait_ack(60, n);
    req = '0;
    repeat (3) tick();

    // Drop during transfer: ack still issued, no second grant
    req_data = {16'h3333, 16'h0000};
    req      = 2'b10;
    push(1, 16'h3333, 0);
    wait_start(10, n);
    tick();
    tick();
    req = '0;
    wait_ack(60, n);
    cnt_bad = 0;
    repeat (10) begin
      tick();
      if (busy) cnt_bad++;
    end
    chk("drop_no_regrant", 32'(cnt_bad), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spim_sequencer.md
# spim_sequencer

Sequencer and round-robin arbiter that shares the single SPI master core (data, length, chip-select, start/idle interface) between several internal requesters, e.g. the SPI-slave register bank and an autonomous slot poller. It latches one requester's transfer descriptor and loads it into the core. It starts the transfer, waits for completion with a timeout, and returns the MISO word to that requester with a one-cycle acknowledge.

## Interface
Parameters:
- N_REQ, 2, number of requesters.
- DATA_W, 16, SPI word width.
- LEN_W, 8, length field width; the value is bits-1, as the core expects.
- CS_W, 1, chip-select mask width.
- TIMEOUT, 65535, maximum cycles from start to completion; the counter is 16 bit.

Ports:
- sys_clk, in, 1, system clock; all logic is on the rising edge.
- sys_rst, in, 1, synchronous, active-high reset.
- req, in, N_REQ, per-requester request level.
- req_data, in, N_REQ*DATA_W, packed MOSI words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_len, in, N_REQ*LEN_W, packed lengths.
- req_cs, in, N_REQ*CS_W, packed chip-select masks.
- ack, out, N_REQ, one-cycle completion pulse to the granted requester.
- err, out, N_REQ, timeout flag, valid only with ack.
- rsp_data, out, DATA_W, MISO word, valid in the ack cycle and held until the next ack.
- busy, out, 1, high whenever the state is not IDLE.
- m_data, out, DATA_W, MOSI word to the core.
- m_len, out, LEN_W, length to the core.
- m_cs, out, CS_W, chip-select mask to the core.
- m_start, out, 1, one-cycle start pulse.
- m_idle, in, 1, core idle status.
- m_miso, in, DATA_W, core receive word.

## Operation
- **States:** IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE:** if any req bit is high, grant the round-robin winner. Latch its data, len and cs into m_data, m_len and m_cs, and store the grant index. Go to LOAD.
- **LOAD:** go to START once m_idle=1; otherwise stay.
- **START:** assert m_start for exactly one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY:** go to WAIT_DONE when m_idle=0.
- **WAIT_DONE:** when m_idle=1, capture m_miso into rsp_data and go to RESP.
- **Timeout:** the counter increments in both WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT, go to RESP with a pending error, rsp_data=0, and no capture.
- **RESP:** pulse ack[grant]. Pulse err[grant] if a timeout occurred. Set the pointer to grant+1, modulo N_REQ. Return to IDLE.
- **Round robin:** search starts at the pointer and increases in index. After reset the pointer is 0, so requester 0 has highest priority first.
- **Requester contract:** hold req and its descriptor stable until ack. A req still high in the cycle after ack (IDLE) is treated as a new request.
- **m_data, m_len, m_cs:** change only in the IDLE-to-LOAD transition and are otherwise stable.
- **Simultaneous requests:** exactly one is granted; the others wait and are never dropped.
- **Deassertion while granted:** a req dropping while that requester is granted is ignored; the transfer completes and is acked anyway.
- **Timeout recovery:** after a timeout the core is not aborted. The next LOAD stalls until m_idle=1.
- **Reset mid-operation:** state goes to IDLE, m_start, ack and err go to 0, and the pointer goes to 0. The in-flight core transfer is abandoned without ack.

## Timing
- **Reset values:** ack=0, err=0, m_start=0, busy=0, rsp_data=0, m_data=0, m_len=0, m_cs=0.
- **Minimum latency:** req sampled in cycle 0 → LOAD in cycle 1 → m_start in cycle 2, provided m_idle=1. Idle observed in cycle k → ack in cycle k+1.
- **m_start:** never asserted while m_idle=0 and never longer than 1 cycle.
- **Back-to-back:** with req held high, one dead cycle (IDLE) separates ack from the next LOAD.
- **Timeout:** ack with err is issued exactly TIMEOUT+1 cycles after m_start.

## Structure
- **Package spim_seq_pkg:** state enum, state encoding width, and the default TIMEOUT constant.
- **Sub-module rr_arbiter:** combinational winner selection from req and pointer, plus a registered pointer update on an advance strobe. Parameter N_REQ.
- **Top level:** the FSM, descriptor latch, timeout counter and rsp_data register.

## Test plan
- **Single requester:** req[0] with data=0xaa55, len=15, cs=1. The core model loops MOSI back. Expect m_start in cycle 2, m_data=0xaa55, m_len=15, ack[0] once, rsp_data equal to the loopback word, err=0.
- **Contention:** req=2'b11 held with distinct data 0x1111 and 0x2222. Expect grants in order 0, 1, 0, 1, and each ack paired with its own response word.
- **Core busy at grant:** m_idle=0 for 10 cycles after the grant. Expect no m_start until m_idle=1, then a single-cycle m_start.
- **Timeout:** TIMEOUT=20 and the core never returns to idle. Expect ack[0] and err[0] 21 cycles after m_start, rsp_data=0. The next request stalls in LOAD until the core model sets m_idle=1.
- **Reset mid-transfer:** sys_rst in WAIT_DONE. Expect busy=0 next cycle, no ack, and requester 0 granted first afterwards.
- **Drop during transfer:** req[1] deasserted mid-transfer. Expect the transfer completes with ack[1] and no second grant.
